// File: rtl/fir_adc_spi.sv
// fir_adc_spi: SPI ADC front end for fir_path.
// Reads one AD7476-style frame per sample period and emits a left-aligned
// signed 16-bit sample x with a one-cycle x_valid strobe.
// Optional build macro: ADC_OFFSET_BIN_EN (ADC delivers offset binary;
// the sign bit is inverted to convert it to two's complement).
module fir_adc_spi #(
    parameter int unsigned ADC_BITS   = 12,
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned LEAD_BITS  = 4,
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned SAMPLE_DIV = 1724
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_n,
    output logic [15:0] x,
    output logic        x_valid,
    output logic        overrun
);

    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned PH_W  = $clog2(2 * SCLK_DIV);
    localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        sample_cnt;
    logic [PH_W-1:0]         ph, ph_nx;
    logic [BIT_W-1:0]        bit_cnt, bit_nx;
    logic [FRAME_BITS-1:0]   shreg;
    logic                    sclk_nx, cs_n_nx;
    logic                    tick_c;
    logic [ADC_BITS-1:0]     d_c, dp_c;
    logic [15:0]             x_fmt_c;

    assign tick_c = en && (sample_cnt == CNT_W'(SAMPLE_DIV - 1));

    // Sample-period timer: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            sample_cnt <= '0;
        end else if (sample_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    // Next-state, phase/bit counters and next values of the SPI pins.
    always_comb begin
        state_nx = state;
        ph_nx    = ph;
        bit_nx   = bit_cnt;
        case (state)
            IDLE: begin
                if (tick_c) begin
                    state_nx = SETUP;
                    ph_nx    = '0;
                end
            end
            SETUP: begin
                if (ph == PH_W'(SCLK_DIV - 1)) begin
                    state_nx = SHIFT;
                    ph_nx    = '0;
                    bit_nx   = '0;
                end else begin
                    ph_nx = ph + PH_W'(1);
                end
            end
            SHIFT: begin
                if (ph == PH_W'(2 * SCLK_DIV - 1)) begin
                    ph_nx = '0;
                    if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                        state_nx = DONE;
                    end else begin
                        bit_nx = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    ph_nx = ph + PH_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Pins follow the state being entered so cs_n drops the cycle after the tick.
        sclk_nx = !((state_nx == SHIFT) && (ph_nx < PH_W'(SCLK_DIV)));
        cs_n_nx = !((state_nx == SETUP) || (state_nx == SHIFT));
    end

    // Sample field extraction and sign handling.
    always_comb begin
        d_c  = shreg[FRAME_BITS-1-LEAD_BITS -: ADC_BITS];
        dp_c = d_c;
`ifdef ADC_OFFSET_BIN_EN
        dp_c[ADC_BITS-1] = ~d_c[ADC_BITS-1];
`endif
        x_fmt_c = 16'(dp_c) << (16 - ADC_BITS);
    end

    // State, counters, SPI pins, shift register and sample outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ph      <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b1;
            cs_n    <= 1'b1;
            shreg   <= '0;
            x       <= '0;
            x_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            ph      <= ph_nx;
            bit_cnt <= bit_nx;
            sclk    <= sclk_nx;
            cs_n    <= cs_n_nx;
            // Capture on the last cycle of each low half, i.e. at the sclk rising edge.
            if ((state == SHIFT) && (ph == PH_W'(SCLK_DIV - 1))) begin
                shreg <= FRAME_BITS'({shreg, miso});
            end
            x_valid <= (state == DONE);
            if (state == DONE) begin
                x <= x_fmt_c;
            end
            if (tick_c && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_adc_spi.sv
// Bench for fir_adc_spi: an ADC model serves random and directed frames to a
// default-parameter instance; a second instance with a short sample period
// exercises overrun. Expected samples come from a frame-level reference.
module tb_fir_adc_spi;

    localparam int unsigned ADC_BITS   = 12;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned LEAD_BITS  = 4;
    localparam int unsigned SAMPLE_DIV = 1724;
    localparam int unsigned FAST_DIV   = 100;
    localparam int unsigned CS_LOW     = 4 + 2 * 4 * FRAME_BITS;   // setup + shift cycles
    localparam int unsigned XV_LAT     = CS_LOW + 1;               // first cs_n low cycle to x_valid

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        miso = 1'b0;
    logic        sclk, cs_n, x_valid, overrun;
    logic [15:0] x;
    logic        sclk_f, cs_n_f, x_valid_f, overrun_f;
    logic [15:0] x_f;

    fir_adc_spi dut (
        .clk(clk), .rst(rst), .en(en), .miso(miso),
        .sclk(sclk), .cs_n(cs_n), .x(x), .x_valid(x_valid), .overrun(overrun)
    );

    fir_adc_spi #(.SAMPLE_DIV(FAST_DIV)) dut_fast (
        .clk(clk), .rst(rst), .en(1'b1), .miso(1'b1),
        .sclk(sclk_f), .cs_n(cs_n_f), .x(x_f), .x_valid(x_valid_f), .overrun(overrun_f)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Frame -> sample, straight from the frame layout and sign rules.
    function automatic logic [15:0] ref_x(input logic [15:0] frame);
        int unsigned d;
        d = (int'(frame) >> (FRAME_BITS - LEAD_BITS - ADC_BITS)) & ((1 << ADC_BITS) - 1);
`ifdef ADC_OFFSET_BIN_EN
        d = d ^ (1 << (ADC_BITS - 1));
`endif
        return 16'(d << (16 - ADC_BITS));
    endfunction

    // Monitor / ADC model state
    logic [15:0] directed_q[$] = '{16'h07FF, 16'h0800, 16'h0FFF, 16'hF800};
    logic [15:0] exp_q[$];
    logic [15:0] adc_sh;
    logic [15:0] frame;
    logic [15:0] e;
    int unsigned falls, low_len, run, start_cyc;
    bit          in_frame = 0;
    logic        prev_sclk = 1'b1, prev_cs = 1'b1, prev_xv = 1'b0;
    logic [15:0] last_x = '0;
    int unsigned xv_count = 0;
    bit          exp_valid = 0;
    int unsigned exp_start = 0;

    // Frame-level monitor and ADC model for the default instance.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_frame  = 0;
            prev_sclk = 1'b1;
            prev_cs   = 1'b1;
            prev_xv   = 1'b0;
            last_x    = '0;
        end else begin
            if (prev_cs && !cs_n) begin
                if (exp_valid) check("frame_start", cyc, exp_start);
                else           check("frame_unexpected", 1, 0);
                exp_start = cyc + SAMPLE_DIV;
                if (directed_q.size() != 0) frame = directed_q.pop_front();
                else                        frame = 16'($urandom);
                adc_sh = frame;
                exp_q.push_back(ref_x(frame));
                in_frame  = 1;
                start_cyc = cyc;
                low_len   = 0;
                falls     = 0;
                run       = 0;
            end
            if (in_frame && !cs_n) begin
                low_len++;
                if (!prev_cs && (sclk != prev_sclk)) begin
                    check("sclk_half", run, 4);
                    run = 0;
                end
                run++;
                if (prev_sclk && !sclk) begin
                    falls++;
                    miso   = adc_sh[15];
                    adc_sh = adc_sh << 1;
                end
            end
            if (in_frame && !prev_cs && cs_n) begin
                check("cs_low_len", low_len, CS_LOW);
                check("sclk_falls", falls, FRAME_BITS);
                check("last_high", run, 4);
                in_frame = 0;
            end
            if (x_valid) begin
                check("xv_pulse", prev_xv, 0);
                check("xv_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("x", x, e);
                end
                check("xv_latency", cyc - start_cyc, XV_LAT);
                last_x = x;
                xv_count++;
            end else begin
                check("x_hold", x, last_x);
            end
            prev_sclk = sclk;
            prev_cs   = cs_n;
            prev_xv   = x_valid;
        end
    end

    int unsigned last_xv_f;
    bit          have_xv_f = 0;

    // Short-period instance: every other tick is lost to overrun.
    always @(negedge clk) begin
        if (rst) begin
            have_xv_f = 0;
        end else if (x_valid_f) begin
            check("fast_x", x_f, ref_x(16'hFFFF));
            if (have_xv_f) check("fast_period", cyc - last_xv_f, 2 * FAST_DIV);
            last_xv_f = cyc;
            have_xv_f = 1;
        end
    end

    task automatic reset_checks();
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 1);
        check("rst_x", x, 0);
        check("rst_xv", x_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fast_x", x_f, 0);
        check("rst_fast_overrun", overrun_f, 0);
        check("rst_fast_cs_n", cs_n_f, 1);
    endtask

    task automatic wait_xv(input int unsigned target, input int unsigned budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (xv_count >= target) break;
            @(negedge clk);
        end
        check(tag, xv_count >= target, 1);
    endtask

    task automatic wait_cs_low(input int unsigned budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (!cs_n) break;
            @(negedge clk);
        end
        check(tag, cs_n, 0);
    endtask

    int unsigned base;

    initial begin
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;
        en  = 1'b1;
        exp_start = cyc + SAMPLE_DIV;
        exp_valid = 1;

        // Abort the first frame with a three-cycle reset.
        wait_cs_low(SAMPLE_DIV + 50, "wait_frame1");
        repeat (50) @(negedge clk);
        rst = 1'b1;
        exp_valid = 0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;
        exp_start = cyc + SAMPLE_DIV;
        exp_valid = 1;

        // Short-period instance: overrun appears at the second tick and sticks.
        repeat (150) @(negedge clk);
        check("fast_overrun_pre", overrun_f, 0);
        repeat (51) @(negedge clk);
        check("fast_overrun_set", overrun_f, 1);
        check("xv_none_after_rst", xv_count, 0);

        // Directed frames, then random ones.
        wait_xv(6, 7 * SAMPLE_DIV, "wait_samples");

        // Drop en mid-frame: that frame completes, nothing follows.
        wait_cs_low(SAMPLE_DIV + 50, "wait_frame_en");
        repeat (20) @(negedge clk);
        base = xv_count;
        en = 1'b0;
        exp_valid = 0;
        repeat (1800) @(negedge clk);
        check("en_drop_xv", xv_count - base, 1);
        check("en_drop_cs_n", cs_n, 1);

        // Re-enable: first tick SAMPLE_DIV-1 cycles later.
        en = 1'b1;
        exp_start = cyc + SAMPLE_DIV;
        exp_valid = 1;
        wait_xv(base + 2, SAMPLE_DIV + 200, "wait_reenable");
        check("overrun_main", overrun, 0);
        check("fast_overrun_sticky", overrun_f, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
